sw_debounce: RTL and testbench

Input conditioning stage in front of the hex-to-seven-segment display path. It synchronizes and debounces the 8 slide switches and one push button on the board. It presents a clean 8-bit value (`sw_db`) to the hex decoders, plus a debounced button level and a single-cycle press pulse. It adds sequential filtering only; it does no decoding of its own.

---
 rtl/sw_debounce.sv | 152 +++++++++++++++
 tb/tb_sw_debounce.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus tick-paced debounce for the eight
// slide switches (filtered as one word) and the push button (press/release FSM).
//
// Ports:
//   clk      - system clock, the only clock
//   reset_n  - synchronous reset, active-low
//   sw       - raw slide switches, asynchronous to clk
//   btn      - raw push button, active-high, asynchronous
//   sw_db    - debounced switch word
//   sw_chg   - one-cycle pulse in the cycle sw_db takes a new value
//   btn_db   - debounced button level
//   btn_tick - one-cycle pulse on an accepted press (0->1 only)
module sw_debounce #(
  parameter int unsigned N            = 19,
  parameter int unsigned STABLE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sw,
  input  logic       btn,
  output logic [7:0] sw_db,
  output logic       sw_chg,
  output logic       btn_db,
  output logic       btn_tick
);

  localparam int unsigned SW_W  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_TICKS);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } btn_state_t;

  logic [SW_W-1:0]  sw_m;
  logic [SW_W-1:0]  sw_s;
  logic             btn_m;
  logic             btn_s;
  logic [N-1:0]     q;
  logic             tick;
  logic [SW_W-1:0]  cand;
  logic [CNT_W-1:0] scnt;
  logic [CNT_W-1:0] scnt_inc;
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] bcnt_inc;
  btn_state_t       state;

  // Two-stage synchronizer, no logic between stages
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Free-running sample-tick counter; wraps silently
  always_ff @(posedge clk) begin
    if (!reset_n) q <= '0;
    else          q <= q + N'(1);
  end

  assign tick     = &q;
  assign scnt_inc = scnt + CNT_W'(1);
  assign bcnt_inc = bcnt + CNT_W'(1);

  // Word-wide switch filter: any mismatch restarts the window and eats the tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand   <= '0;
      scnt   <= '0;
      sw_db  <= '0;
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= 1'b0;
      if (sw_s != cand) begin
        cand <= sw_s;
        scnt <= '0;
      end else if (tick && (scnt < STABLE)) begin
        scnt <= scnt_inc;
        // Accept only on the tick that completes the window, and only if new
        if ((scnt_inc == STABLE) && (cand != sw_db)) begin
          sw_db  <= cand;
          sw_chg <= 1'b1;
        end
      end
    end
  end

  // Button press/release FSM with registered level and press pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ZERO;
      bcnt     <= '0;
      btn_db   <= 1'b0;
      btn_tick <= 1'b0;
    end else begin
      btn_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (btn_s) begin
            state <= WAIT1;
            bcnt  <= '0;
          end
        end
        WAIT1: begin
          if (!btn_s) begin
            state <= ZERO;
          end else if (tick) begin
            bcnt <= bcnt_inc;
            if (bcnt_inc == STABLE) begin
              state    <= ONE;
              btn_db   <= 1'b1;
              btn_tick <= 1'b1;
            end
          end
        end
        ONE: begin
          if (!btn_s) begin
            state <= WAIT0;
            bcnt  <= '0;
          end
        end
        WAIT0: begin
          if (btn_s) begin
            state <= ONE;
          end else if (tick) begin
            bcnt <= bcnt_inc;
            if (bcnt_inc == STABLE) begin
              state  <= ZERO;
              btn_db <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ZERO;
          btn_db <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus randomized traffic for sw_debounce,
// checked every cycle against a run-length reference model and against the
// latency/pulse bounds of each scenario.
module tb_sw_debounce;

  localparam int N   = 4;
  localparam int ST  = 2;
  localparam int PER = 16;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw      = 8'h00;
  logic       btn     = 1'b0;
  logic [7:0] sw_db;
  logic       sw_chg;
  logic       btn_db;
  logic       btn_tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_debounce #(.N(N), .STABLE_TICKS(ST)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (sw),
    .btn      (btn),
    .sw_db    (sw_db),
    .sw_chg   (sw_chg),
    .btn_db   (btn_db),
    .btn_tick (btn_tick)
  );

  // Reference model: a synchronized value is accepted once it has stayed
  // unchanged through ST sample ticks after the cycle it first appeared.
  int         m_q;
  logic [7:0] m_s1, m_s2, m_run, m_db;
  int         m_rt;
  logic       m_chg;
  logic       m_b1, m_b2, m_brun, m_bdb, m_btick;
  int         m_bt;

  always @(posedge clk) begin
    bit tk;
    if (!reset_n) begin
      m_q = 0; m_s1 = 0; m_s2 = 0; m_run = 0; m_db = 0; m_rt = 0; m_chg = 0;
      m_b1 = 0; m_b2 = 0; m_brun = 0; m_bdb = 0; m_bt = 0; m_btick = 0;
    end else begin
      tk = (m_q == PER - 1);
      m_chg = 0;
      m_btick = 0;
      if (m_s2 != m_run) begin
        m_run = m_s2; m_rt = 0;
      end else if (tk) begin
        m_rt++;
        if (m_rt == ST && m_run != m_db) begin m_db = m_run; m_chg = 1; end
      end
      if (m_b2 != m_brun) begin
        m_brun = m_b2; m_bt = 0;
      end else if (tk) begin
        m_bt++;
        if (m_bt == ST && m_brun != m_bdb) begin m_bdb = m_brun; m_btick = m_brun; end
      end
      m_q = (m_q + 1) % PER;
      m_s2 = m_s1; m_s1 = sw;
      m_b2 = m_b1; m_b1 = btn;
    end
  end

  task automatic test_reset();
    int chg_n = 0;
    reset_n = 1'b0; sw = 8'hA5; btn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== 11'h000) begin
        errors++;
        $display("FAIL reset_hold: got db=%h chg=%b bdb=%b btick=%b, want all 0", sw_db, sw_chg, btn_db, btn_tick);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sw_chg) chg_n++;
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL reset_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
      if (k == 35) begin
        checks++;
        if (sw_db !== 8'hA5) begin
          errors++;
          $display("FAIL reset_exit_value: got sw_db=%h, want a5 within 35 clocks", sw_db);
        end
      end
    end
    checks++;
    if (chg_n != 1) begin
      errors++;
      $display("FAIL reset_exit_chg: got %0d sw_chg pulses, want 1", chg_n);
    end
    btn = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL reset_settle t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
  endtask

  task automatic test_clean_change();
    int chg_n = 0;
    int first_k = 0;
    sw = 8'h00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL clean_settle t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    sw = 8'h3C;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sw_chg) chg_n++;
      if (sw_db === 8'h3C && first_k == 0) first_k = k;
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL clean_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
      if (k <= 19) begin
        checks++;
        if (sw_db !== 8'h00) begin
          errors++;
          $display("FAIL clean_early k=%0d: got sw_db=%h, want 00", k, sw_db);
        end
      end
    end
    checks++;
    if (first_k == 0 || first_k > 35) begin
      errors++;
      $display("FAIL clean_latency: got %0d clocks, want 20..35", first_k);
    end
    checks++;
    if (chg_n != 1) begin
      errors++;
      $display("FAIL clean_chg: got %0d pulses, want 1", chg_n);
    end
  endtask

  task automatic test_bounce();
    int chg_tog = 0;
    int chg_n = 0;
    int first_k = 0;
    sw = 8'h00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL bounce_settle t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    for (int seg = 0; seg < 10; seg++) begin
      sw = (seg % 2 == 0) ? 8'h01 : 8'h00;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (sw_chg) chg_tog++;
        checks++;
        if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
          errors++;
          $display("FAIL bounce_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
        end
      end
    end
    checks++;
    if (chg_tog != 0) begin
      errors++;
      $display("FAIL bounce_no_chg: got %0d pulses while toggling, want 0", chg_tog);
    end
    sw = 8'h01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sw_chg) chg_n++;
      if (sw_db === 8'h01 && first_k == 0) first_k = k;
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL bounce_hold t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    checks++;
    if (first_k == 0 || first_k > 35 || chg_n != 1) begin
      errors++;
      $display("FAIL bounce_accept: got latency %0d and %0d pulses, want <=35 and 1", first_k, chg_n);
    end
  endtask

  task automatic test_revert();
    sw = 8'h00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL revert_settle t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    // Phase the glitch so its window holds a single tick
    for (int w = 0; w < PER && m_q != 6; w++) @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      sw = (k < 20) ? 8'h80 : 8'h00;
      @(negedge clk);
      checks++;
      if (sw_db !== 8'h00 || sw_chg !== 1'b0) begin
        errors++;
        $display("FAIL revert_hold k=%0d: got sw_db=%h chg=%b, want 00/0", k, sw_db, sw_chg);
      end
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL revert_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
  endtask

  task automatic test_button_press();
    int tick_press = 0;
    int tick_rel = 0;
    for (int i = 0; i < 106; i++) begin
      btn = (i < 6) ? (i % 2 == 0) : 1'b1;
      repeat ((i < 6) ? 2 : 1) begin
        @(negedge clk);
        if (btn_tick) tick_press++;
        checks++;
        if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
          errors++;
          $display("FAIL press_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
        end
      end
    end
    checks++;
    if (tick_press != 1 || btn_db !== 1'b1) begin
      errors++;
      $display("FAIL press_tick: got %0d pulses, btn_db=%b; want 1 pulse, btn_db=1", tick_press, btn_db);
    end
    btn = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (btn_tick) tick_rel++;
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL release_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
      if (k <= 17) begin
        checks++;
        if (btn_db !== 1'b1) begin
          errors++;
          $display("FAIL release_early k=%0d: got btn_db=%b, want 1", k, btn_db);
        end
      end
    end
    checks++;
    if (tick_rel != 0 || btn_db !== 1'b0) begin
      errors++;
      $display("FAIL release_end: got %0d pulses, btn_db=%b; want 0 pulses, btn_db=0", tick_rel, btn_db);
    end
  endtask

  task automatic test_reset_mid_press();
    int tick_n = 0;
    int first_k = 0;
    btn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL midrst_pre t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (btn_db !== 1'b0 || btn_tick !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold: got btn_db=%b btn_tick=%b, want 0/0", btn_db, btn_tick);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (btn_tick) begin
        tick_n++;
        if (first_k == 0) first_k = k;
      end
      checks++;
      if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
        errors++;
        $display("FAIL midrst_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
      end
    end
    checks++;
    if (tick_n != 1 || first_k < 20 || first_k > 35) begin
      errors++;
      $display("FAIL midrst_window: got %0d pulses first at %0d, want 1 pulse at 20..35", tick_n, first_k);
    end
    btn = 1'b0;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 150; seg++) begin
      int hold;
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 2) == 0) sw = 8'($urandom());
      else                           sw = sw ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) btn = ~btn;
      reset_n = ($urandom_range(0, 24) != 0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!reset_n && k >= 2) reset_n = 1'b1;
        checks++;
        if ({sw_db, sw_chg, btn_db, btn_tick} !== {m_db, m_chg, m_bdb, m_btick}) begin
          errors++;
          $display("FAIL random_model t=%0t: got %h/%b/%b/%b want %h/%b/%b/%b", $time, sw_db, sw_chg, btn_db, btn_tick, m_db, m_chg, m_bdb, m_btick);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_change();
    test_bounce();
    test_revert();
    test_button_press();
    test_reset_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
